lsu_ctrl: RTL and testbench

Parametrised load/store controller between the MEM pipeline stage and data memory. It accepts one access at a time over a valid/ready handshake and performs the memory transaction with variable grant and read latency. It generates aligned addresses, byte enables and lane-replicated store data, and returns sign- or zero-extended load results. Misaligned or oversized accesses complete with an error flag and never reach memory.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_ctrl_load_align.sv | 32 +++
 rtl/lsu_ctrl.sv | 145 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and byte-enable helper for the load/store controller.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Byte enables for 2^size bytes starting at lane, clipped to data_w/8 lanes.
  function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [2:0] lane,
                                        input int unsigned data_w);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << size)) - 16'd1;
    m = m << lane;
    return m[7:0] & ~(8'hFF << (data_w / 8));
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Load data path: shift the addressed lane down, keep the access width, extend.
module load_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]            rdata_i,
  input  logic [$clog2(DATA_W/8)-1:0]  lane_i,
  input  logic [1:0]                   size_i,
  input  logic                         signed_i,
  output logic [DATA_W-1:0]            data_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              msb;

  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    mask    = '1;
    msb     = 1'b0;
    case (size_i)
      SZ_BYTE: begin mask = DATA_W'(8'hFF);         msb = shifted[7];  end
      SZ_HALF: begin mask = DATA_W'(16'hFFFF);      msb = shifted[15]; end
      SZ_WORD: begin mask = DATA_W'(32'hFFFF_FFFF); msb = shifted[31]; end
      default: ;
    endcase
    // A full-width access has ~mask == 0, so signedness drops out naturally.
    data_o = (shifted & mask) | ((signed_i && msb) ? ~mask : '0);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and data memory: one access at a time,
// aligned address/byte-enable generation, lane-replicated stores, extended loads.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [TAG_W-1:0]    tag_q;
  logic                accept;
  logic                illegal;
  logic [2:0]          align_mask;
  logic [DATA_W-1:0]   wdata_rep;
  logic [DATA_W-1:0]   load_data;

  // Request decode: alignment / size legality and store-data replication.
  always_comb begin
    align_mask = 3'd7;
    wdata_rep  = req_wdata;
    case (req_size)
      SZ_BYTE: begin align_mask = 3'd0; wdata_rep = {BE_W{req_wdata[7:0]}};         end
      SZ_HALF: begin align_mask = 3'd1; wdata_rep = {(BE_W/2){req_wdata[15:0]}};    end
      SZ_WORD: begin align_mask = 3'd3; wdata_rep = {(BE_W/4){req_wdata[31:0]}};    end
      default: ;
    endcase
    illegal = (|(3'(req_addr[LANE_W-1:0]) & align_mask)) || ((32'd1 << req_size) > BE_W);
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b1;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = illegal ? S_RESP : S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = mem_we ? S_RESP : S_WAIT;
      end
      S_WAIT: if (mem_rvalid) state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Request capture and response registers; rsp_* change only on entry to RESP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      tag_q     <= '0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        mem_we    <= req_we;
        mem_addr  <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        mem_be    <= BE_W'(be_gen(req_size, 3'(req_addr[LANE_W-1:0]), DATA_W));
        mem_wdata <= wdata_rep;
        lane_q    <= req_addr[LANE_W-1:0];
        size_q    <= req_size;
        signed_q  <= req_signed;
        tag_q     <= req_tag;
        if (illegal) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
          rsp_tag  <= req_tag;
        end
      end
      if (state_q == S_REQ && mem_gnt && mem_we) begin
        rsp_data <= '0;
        rsp_err  <= 1'b0;
        rsp_tag  <= tag_q;
      end
      if (state_q == S_WAIT && mem_rvalid) begin
        rsp_data <= load_data;
        rsp_err  <= 1'b0;
        rsp_tag  <= tag_q;
      end
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata_i  (mem_rdata),
    .lane_i   (lane_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (load_data)
  );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: a 32-bit instance for most scenarios
// and a 64-bit instance for wide lane/extension cases.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_req_signed;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_mem_addr, a_mem_wdata, a_mem_rdata, a_rsp_data;
  logic [4:0]  a_req_tag, a_rsp_tag;
  logic        a_mem_req, a_mem_we, a_mem_gnt, a_mem_rvalid, a_rsp_valid, a_rsp_err, a_busy;
  logic [3:0]  a_mem_be;

  logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_req_signed;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_mem_addr;
  logic [63:0] b_req_wdata, b_mem_wdata, b_mem_rdata, b_rsp_data;
  logic [4:0]  b_req_tag, b_rsp_tag;
  logic        b_mem_req, b_mem_we, b_mem_gnt, b_mem_rvalid, b_rsp_valid, b_rsp_err, b_busy;
  logic [7:0]  b_mem_be;

  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset_n(a_rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_tag(a_req_tag),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
    .mem_wdata(a_mem_wdata), .mem_gnt(a_mem_gnt), .mem_rvalid(a_mem_rvalid),
    .mem_rdata(a_mem_rdata),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_tag(a_rsp_tag),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  lsu_ctrl #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) dut64 (
    .clk(clk), .reset_n(b_rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_tag(b_req_tag),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_gnt(b_mem_gnt), .mem_rvalid(b_mem_rvalid),
    .mem_rdata(b_mem_rdata),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_tag(b_rsp_tag),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  // Drives one access on the 32-bit instance (accepted from IDLE) and plays memory:
  // grant after gnt_dly REQ cycles, rvalid rv_dly cycles after the cycle following grant.
  // Cycle numbers are relative to the accepting edge (cycle 1 is the first after it).
  task automatic run32(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] tag,
                       input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                       output int req_cyc, output int rsp_at, output int pulses,
                       output logic [3:0] be, output logic [31:0] maddr,
                       output logic [31:0] mwdata, output logic mwe,
                       output logic [31:0] rdat, output logic [4:0] rtag, output logic rerr,
                       output logic ready_after);
    int   gcnt;
    int   gcyc;
    logic granted;
    req_cyc = 0; rsp_at = 0; pulses = 0; gcnt = 0; gcyc = 0; granted = 1'b0;
    be = '0; maddr = '0; mwdata = '0; mwe = 1'b0; rdat = '0; rtag = '0; rerr = 1'b0;
    ready_after = 1'b0;
    @(negedge clk);
    a_req_we = we; a_req_size = size; a_req_signed = sgn; a_req_addr = addr;
    a_req_wdata = wdata; a_req_tag = tag; a_req_valid = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc > 1) @(negedge clk);
      a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = 32'h5A5A_5A5A;
      if (a_mem_req) begin
        if (req_cyc == 0) begin
          be = a_mem_be; maddr = a_mem_addr; mwdata = a_mem_wdata; mwe = a_mem_we;
        end
        req_cyc++;
        if (gcnt == gnt_dly) begin a_mem_gnt = 1'b1; granted = 1'b1; gcyc = cyc; end
        else gcnt++;
      end
      if (!we && granted && cyc == gcyc + 1 + rv_dly) begin
        a_mem_rvalid = 1'b1; a_mem_rdata = rdata;
      end
      if (a_rsp_valid) begin
        pulses++;
        if (rsp_at == 0) begin
          rsp_at = cyc; rdat = a_rsp_data; rtag = a_rsp_tag; rerr = a_rsp_err;
        end
      end
      if (rsp_at != 0 && cyc == rsp_at + 1) begin
        ready_after = a_req_ready;
        break;
      end
    end
    a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", a_req_ready); end
    checks++; if ({a_mem_req, a_mem_we, a_mem_be} !== 6'b0) begin failures++; $display("FAIL rst_mem_ctl got=%b exp=0", {a_mem_req, a_mem_we, a_mem_be}); end
    checks++; if ({a_mem_addr, a_mem_wdata} !== 64'h0) begin failures++; $display("FAIL rst_mem_data got=%h exp=0", {a_mem_addr, a_mem_wdata}); end
    checks++; if ({a_rsp_valid, a_rsp_err, a_rsp_tag, a_rsp_data} !== 39'h0) begin failures++; $display("FAIL rst_rsp got=%h exp=0", {a_rsp_valid, a_rsp_err, a_rsp_tag, a_rsp_data}); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
    checks++; if ({b_req_ready, b_busy, b_mem_req, b_rsp_valid, b_mem_be} !== 12'b1000_0000_0000) begin failures++; $display("FAIL rst_b got=%b exp=100000000000", {b_req_ready, b_busy, b_mem_req, b_rsp_valid, b_mem_be}); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed_byte_load();
    int rc, ra, pl; logic [3:0] be; logic [31:0] ma, mw, rd; logic we, re, rdy; logic [4:0] rt;
    run32(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd7, 32'h80AB_CD12, 0, 2,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if (ma !== 32'h1000) begin failures++; $display("FAIL sbl_addr got=%h exp=00001000", ma); end
    checks++; if (be !== 4'b1000) begin failures++; $display("FAIL sbl_be got=%b exp=1000", be); end
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL sbl_data got=%h exp=ffffff80", rd); end
    checks++; if ({re, rt} !== {1'b0, 5'd7}) begin failures++; $display("FAIL sbl_err_tag got=%b/%0d exp=0/7", re, rt); end
    checks++; if (ra !== 5) begin failures++; $display("FAIL sbl_rsp_cycle got=%0d exp=5", ra); end
    checks++; if (pl !== 1) begin failures++; $display("FAIL sbl_pulses got=%0d exp=1", pl); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL sbl_ready_after got=%b exp=1", rdy); end
    checks++; if (a_rsp_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL sbl_hold got=%h exp=ffffff80", a_rsp_data); end
  endtask

  task automatic test_half_load();
    int rc, ra, pl; logic [3:0] be; logic [31:0] ma, mw, rd; logic we, re, rdy; logic [4:0] rt;
    run32(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 5'd5, 32'h8001_7FFF, 0, 0,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if (be !== 4'b1100) begin failures++; $display("FAIL uhl_be got=%b exp=1100", be); end
    checks++; if (rd !== 32'h0000_8001) begin failures++; $display("FAIL uhl_data got=%h exp=00008001", rd); end
    checks++; if (ra !== 3) begin failures++; $display("FAIL uhl_rsp_cycle got=%0d exp=3", ra); end
    run32(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 5'd6, 32'h8001_7FFF, 0, 0,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if (rd !== 32'hFFFF_8001) begin failures++; $display("FAIL shl_data got=%h exp=ffff8001", rd); end
    checks++; if (rt !== 5'd6) begin failures++; $display("FAIL shl_tag got=%0d exp=6", rt); end
  endtask

  task automatic test_errors();
    int rc, ra, pl; logic [3:0] be; logic [31:0] ma, mw, rd; logic we, re, rdy; logic [4:0] rt;
    run32(1'b0, 2'd2, 1'b0, 32'h0005, 32'h0, 5'd11, 32'h0, 0, 0,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if (rc !== 0) begin failures++; $display("FAIL mis_memreq got=%0d exp=0", rc); end
    checks++; if (ra !== 1) begin failures++; $display("FAIL mis_rsp_cycle got=%0d exp=1", ra); end
    checks++; if ({re, rt, rd} !== {1'b1, 5'd11, 32'h0}) begin failures++; $display("FAIL mis_rsp got=%b/%0d/%h exp=1/11/0", re, rt, rd); end
    run32(1'b0, 2'd3, 1'b0, 32'h0008, 32'h0, 5'd12, 32'h0, 0, 0,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if (rc !== 0) begin failures++; $display("FAIL dw32_memreq got=%0d exp=0", rc); end
    checks++; if ({ra, pl} !== {32'd1, 32'd1}) begin failures++; $display("FAIL dw32_timing got=%0d/%0d exp=1/1", ra, pl); end
    checks++; if ({re, rt} !== {1'b1, 5'd12}) begin failures++; $display("FAIL dw32_rsp got=%b/%0d exp=1/12", re, rt); end
    run32(1'b1, 2'd1, 1'b0, 32'h0003, 32'h1234, 5'd13, 32'h0, 0, 0,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if ({rc, ra, re} !== {32'd0, 32'd1, 1'b1}) begin failures++; $display("FAIL mis_half_st got=%0d/%0d/%b exp=0/1/1", rc, ra, re); end
  endtask

  task automatic test_stores();
    int rc, ra, pl; logic [3:0] be; logic [31:0] ma, mw, rd; logic we, re, rdy; logic [4:0] rt;
    run32(1'b1, 2'd1, 1'b0, 32'h0006, 32'h0000_BEEF, 5'd3, 32'h0, 3, 0,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if (be !== 4'b1100) begin failures++; $display("FAIL hst_be got=%b exp=1100", be); end
    checks++; if (mw !== 32'hBEEF_BEEF) begin failures++; $display("FAIL hst_wdata got=%h exp=beefbeef", mw); end
    checks++; if ({we, ma} !== {1'b1, 32'h4}) begin failures++; $display("FAIL hst_we_addr got=%b/%h exp=1/00000004", we, ma); end
    checks++; if (rc !== 4) begin failures++; $display("FAIL hst_req_cycles got=%0d exp=4", rc); end
    checks++; if (ra !== 5) begin failures++; $display("FAIL hst_rsp_cycle got=%0d exp=5", ra); end
    checks++; if ({re, rt, rd} !== {1'b0, 5'd3, 32'h0}) begin failures++; $display("FAIL hst_rsp got=%b/%0d/%h exp=0/3/0", re, rt, rd); end
    run32(1'b1, 2'd0, 1'b0, 32'h0001, 32'h1234_5678, 5'd8, 32'h0, 0, 0,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if ({be, mw} !== {4'b0010, 32'h7878_7878}) begin failures++; $display("FAIL bst_be_wdata got=%b/%h exp=0010/78787878", be, mw); end
    checks++; if ({rc, ra} !== {32'd1, 32'd2}) begin failures++; $display("FAIL bst_timing got=%0d/%0d exp=1/2", rc, ra); end
  endtask

  // req_valid held while busy: fields presented during RESP must not be sampled.
  task automatic test_back_to_back();
    @(negedge clk);
    a_req_we = 1'b0; a_req_size = 2'd3; a_req_signed = 1'b0; a_req_addr = 32'h0;
    a_req_tag = 5'd9; a_req_valid = 1'b1;
    @(negedge clk);
    checks++; if ({a_rsp_valid, a_rsp_tag, a_req_ready} !== {1'b1, 5'd9, 1'b0}) begin failures++; $display("FAIL b2b_first got=%b/%0d/%b exp=1/9/0", a_rsp_valid, a_rsp_tag, a_req_ready); end
    a_req_size = 2'd2; a_req_addr = 32'h2; a_req_tag = 5'd20;
    @(negedge clk);
    checks++; if ({a_rsp_valid, a_rsp_tag, a_req_ready} !== {1'b0, 5'd9, 1'b1}) begin failures++; $display("FAIL b2b_idle got=%b/%0d/%b exp=0/9/1", a_rsp_valid, a_rsp_tag, a_req_ready); end
    @(negedge clk);
    a_req_valid = 1'b0;
    checks++; if ({a_rsp_valid, a_rsp_tag, a_rsp_err} !== {1'b1, 5'd20, 1'b1}) begin failures++; $display("FAIL b2b_second got=%b/%0d/%b exp=1/20/1", a_rsp_valid, a_rsp_tag, a_rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int rc, ra, pl; logic [3:0] be; logic [31:0] ma, mw, rd; logic we, re, rdy; logic [4:0] rt;
    @(negedge clk);
    a_req_we = 1'b0; a_req_size = 2'd1; a_req_signed = 1'b0; a_req_addr = 32'h0;
    a_req_tag = 5'd4; a_req_valid = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    checks++; if (a_mem_req !== 1'b1) begin failures++; $display("FAIL rw_memreq got=%b exp=1", a_mem_req); end
    a_mem_gnt = 1'b1;
    @(negedge clk);
    a_mem_gnt = 1'b0;
    checks++; if ({a_busy, a_mem_req} !== 2'b10) begin failures++; $display("FAIL rw_wait got=%b exp=10", {a_busy, a_mem_req}); end
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1; a_mem_rvalid = 1'b1; a_mem_rdata = 32'hFFFF_FFFF;
    checks++; if ({a_busy, a_req_ready, a_mem_req, a_rsp_valid} !== 4'b0100) begin failures++; $display("FAIL rw_after_rst got=%b exp=0100", {a_busy, a_req_ready, a_mem_req, a_rsp_valid}); end
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    checks++; if ({a_busy, a_rsp_valid, a_rsp_data} !== 34'h0) begin failures++; $display("FAIL rw_late_rvalid got=%b/%b/%h exp=0/0/0", a_busy, a_rsp_valid, a_rsp_data); end
    run32(1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 5'd14, 32'h0000_A500, 0, 0,
          rc, ra, pl, be, ma, mw, we, rd, rt, re, rdy);
    checks++; if ({rd, rt, re} !== {32'h0000_00A5, 5'd14, 1'b0}) begin failures++; $display("FAIL rw_next got=%h/%0d/%b exp=000000a5/14/0", rd, rt, re); end
    checks++; if (ra !== 3) begin failures++; $display("FAIL rw_next_cycle got=%0d exp=3", ra); end
  endtask

  task automatic test_dw64();
    @(negedge clk);
    b_req_we = 1'b0; b_req_size = 2'd2; b_req_signed = 1'b1; b_req_addr = 32'h0C;
    b_req_tag = 5'd2; b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    checks++; if ({b_mem_req, b_mem_be} !== {1'b1, 8'hF0}) begin failures++; $display("FAIL w64_be got=%b/%h exp=1/f0", b_mem_req, b_mem_be); end
    checks++; if (b_mem_addr !== 32'h8) begin failures++; $display("FAIL w64_addr got=%h exp=00000008", b_mem_addr); end
    b_mem_gnt = 1'b1;
    @(negedge clk);
    b_mem_gnt = 1'b0; b_mem_rvalid = 1'b1; b_mem_rdata = 64'hF000_0000_1234_5678;
    @(negedge clk);
    b_mem_rvalid = 1'b0;
    checks++; if ({b_rsp_valid, b_rsp_err, b_rsp_tag} !== {1'b1, 1'b0, 5'd2}) begin failures++; $display("FAIL w64_rsp got=%b/%b/%0d exp=1/0/2", b_rsp_valid, b_rsp_err, b_rsp_tag); end
    checks++; if (b_rsp_data !== 64'hFFFF_FFFF_F000_0000) begin failures++; $display("FAIL w64_data got=%h exp=fffffffff0000000", b_rsp_data); end
    @(negedge clk);
    b_req_we = 1'b1; b_req_size = 2'd3; b_req_addr = 32'h10;
    b_req_wdata = 64'h0123_4567_89AB_CDEF; b_req_tag = 5'd1; b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    checks++; if ({b_mem_be, b_mem_wdata} !== {8'hFF, 64'h0123_4567_89AB_CDEF}) begin failures++; $display("FAIL d64_store got=%h/%h exp=ff/0123456789abcdef", b_mem_be, b_mem_wdata); end
    b_mem_gnt = 1'b1;
    @(negedge clk);
    b_mem_gnt = 1'b0;
    checks++; if ({b_rsp_valid, b_rsp_data} !== {1'b1, 64'h0}) begin failures++; $display("FAIL d64_rsp got=%b/%h exp=1/0", b_rsp_valid, b_rsp_data); end
    @(negedge clk);
  endtask

  initial begin
    a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'd0; a_req_signed = 1'b0;
    a_req_addr = '0; a_req_wdata = '0; a_req_tag = '0;
    a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = '0;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'd0; b_req_signed = 1'b0;
    b_req_addr = '0; b_req_wdata = '0; b_req_tag = '0;
    b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = '0;
    test_reset();
    test_signed_byte_load();
    test_half_load();
    test_errors();
    test_stores();
    test_back_to_back();
    test_reset_in_wait();
    test_dw64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
